sdft_bin_engine: RTL and testbench
==================================

// Module: sdft_bin_engine
// PURPOSE
// Sliding-DFT front end, placed directly upstream of the single-sample IDFT stage.
// - Each accepted time sample updates all N frequency bins through the recursive resonator:
//   X_k <= (X_k + x[n] - x[n-N]) * W^k, where W^k = exp(+j*2*pi*k/N).
// - The updated bins are streamed out one per clock, framed by sob_o/eob_o.
// - Internal storage: an N-deep sample delay line, an N-deep complex bin RAM and a twiddle ROM.
// PARAMETERS
// DW  16             input sample width, signed
// N   4096           number of bins / window length; power of two, >= 8
// AW  $clog2(N)      bin/address width
// BW  DW+AW          bin accumulator and output width, signed
// TW  18             twiddle width, signed Q1.(TW-1), built at elaboration
// PORTS
// clk_i        in   1   clock
// rst_n_i      in   1   asynchronous reset, active low
// sample_i     in   DW  signed time sample
// sample_en_i  in   1   sample valid; accepted only while ready_o=1
// ready_o      out  1   engine idle and able to accept a sample
// overrun_o    out  1   one-cycle pulse: sample_en_i arrived while ready_o=0 (sample dropped)
// sob_o        out  1   start of bin frame (bin 0)
// eob_o        out  1   end of bin frame (bin N-1)
// freq_re_o    out  BW  signed real part of current bin
// freq_im_o    out  BW  signed imaginary part of current bin
// freq_en_o    out  1   bin valid; high from sob_o to eob_o inclusive
// BEHAVIOUR
// - Reset (async assert, sync release): ready_o, overrun_o, sob_o, eob_o and freq_en_o are 0;
//   freq_re_o/freq_im_o are 0; state = CLEAR.
// - FSM states: CLEAR -> IDLE -> DIFF -> SWEEP -> IDLE.
//   - CLEAR: writes 0 to delay-line address a and bin-RAM address a for a = 0..N-1 (N cycles),
//     then goes to IDLE. RAM contents are never assumed reset.
//   - IDLE: ready_o=1. A sample_en_i in this state is accepted (call it cycle 0) and the FSM goes to DIFF.
//   - DIFF (cycle 1): reads x[n-N] at delay pointer p, writes sample_i to p, increments p mod N;
//     forms diff = sample_i - x[n-N], DW+1 bits, exact.
//   - SWEEP: issues bin address k = 0..N-1 on cycles 2..N+1, then returns to IDLE after the last bin
//     has drained. Pipeline: RAM/ROM read, add diff, complex multiply, round/saturate, write back.
// - Output timing: bin k appears on freq_*_o at cycle k+5.
//   - sob_o is high at cycle 5; eob_o is high at cycle N+4; freq_en_o is high on cycles 5..N+4.
//   - ready_o returns to 1 at cycle N+5. Minimum sample period is N+5 clocks.
// - Arithmetic:
//   - s = X_k + diff, computed at BW+1 bits.
//   - Products are full width; the real and imaginary sums are rounded half-up by TW-1 bits.
//   - The result is saturated to [-2^(BW-1), 2^(BW-1)-1]. The saturated value is both the value
//     written back and the value output.
// - Twiddles:
//   - Stored as round((2^(TW-1)-1) * cos/sin(2*pi*k/N)), so +1.0 is represented as 2^(TW-1)-1.
//   - Bin 0 uses an exact bypass: the multiply is skipped and X_0 = s exactly.
// - Write-back at cycle k+5 versus read of k+1: different addresses, so there is no hazard.
//   The next frame cannot start before write-back completes, since ready_o gates acceptance.
// - Outputs freq_re_o/freq_im_o hold their last value when freq_en_o=0.
// - sample_en_i while ready_o=0 (CLEAR, DIFF or SWEEP): the sample is dropped, overrun_o pulses
//   in the following cycle, and the frame in progress is unaffected.
// - Simultaneous eob_o and a new sample_en_i: the sample is dropped (ready_o is still 0 at cycle N+4).
// - Reset asserted mid-operation: all state aborts immediately; on release the full CLEAR runs again.
//   No partial frame is emitted.
// TESTING (N=16 unless noted)
// - Reset release -> ready_o=0 for exactly 16 cycles, then 1. All outputs 0 throughout.
// - Impulse: feed 1000 then zeros -> first frame: bin0=(1000,0), bin4=(~0,~1000),
//   bin8=(~-1000,~0), each within +-1 LSB. sob_o at cycle 5, eob_o at cycle 20.
// - DC: 16 samples of 100, then one more -> bin0 re=1600 im=0 exactly;
//   bins 1..15 within +-16 LSB of 0.
// - Overrun: sample_en_i at cycle 3 of a sweep -> overrun_o one pulse at cycle 4;
//   bin values are identical to a run without the extra sample_en_i.
// - Reset mid-sweep (cycle 10): no further freq_en_o. After release, a 16-cycle CLEAR;
//   then an impulse of 1000 gives bin0=1000 exactly.
// - Saturation (DW=16, BW=16 override): repeated full-scale DC input ->
//   bin0 clamps at 32767 and never wraps negative.

Source files
------------

// File: rtl/sdft_bin_engine_if.sv
// Streaming bus of the sliding-DFT bin engine: time samples in, framed frequency bins out.
interface sdft_bin_engine_if #(
    parameter int DW = 16,
    parameter int BW = 28
);
    logic signed [DW-1:0] sample_i;
    logic                 sample_en_i;
    logic                 ready_o;
    logic                 overrun_o;
    logic                 sob_o;
    logic                 eob_o;
    logic signed [BW-1:0] freq_re_o;
    logic signed [BW-1:0] freq_im_o;
    logic                 freq_en_o;

    modport master (
        output sample_i, sample_en_i,
        input  ready_o, overrun_o, sob_o, eob_o, freq_re_o, freq_im_o, freq_en_o
    );

    modport slave (
        input  sample_i, sample_en_i,
        output ready_o, overrun_o, sob_o, eob_o, freq_re_o, freq_im_o, freq_en_o
    );
endinterface

// File: rtl/sdft_bin_engine.sv
// Sliding-DFT engine: every accepted sample updates all N bins via X_k <= (X_k + x[n] - x[n-N]) * W^k
// and streams the refreshed bins out one per clock, framed by sob/eob.
module sdft_bin_engine #(
    parameter int DW = 16,
    parameter int N  = 4096,
    parameter int AW = $clog2(N),
    parameter int BW = DW + AW,
    parameter int TW = 18
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    sdft_bin_engine_if.slave  bus
);
    // s is widened so X + diff never wraps, even when BW is overridden down to DW
    localparam int SW  = ((BW > DW) ? BW : DW + 1) + 1;
    localparam int PW  = SW + TW;
    localparam int PW1 = PW + 1;

    localparam logic signed [PW:0] HALF = PW1'(64'sd1 <<< (TW - 2));
    localparam logic signed [PW:0] SMAX = PW1'((64'sd1 <<< (BW - 1)) - 64'sd1);
    localparam logic signed [PW:0] SMIN = PW1'(-(64'sd1 <<< (BW - 1)));

    localparam logic [AW+1:0] CLEAR_LAST = (AW + 2)'(N - 1);
    localparam logic [AW+1:0] SWEEP_LAST = (AW + 2)'(N + 2);
    localparam logic [AW+1:0] NBINS      = (AW + 2)'(N);
    localparam logic [AW-1:0] LAST_BIN   = AW'(N - 1);

    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = (2.0 ** (TW - 1)) - 1.0;

    typedef enum logic [1:0] {CLEAR, IDLE, DIFF, SWEEP} state_t;

    state_t               state_reg;
    logic [AW+1:0]        cnt_reg;
    logic [AW-1:0]        ptr_reg;
    logic signed [DW-1:0] sample_reg;
    logic signed [DW:0]   diff_reg;
    logic                 ready_reg;
    logic                 overrun_reg;

    logic signed [DW-1:0] dl_mem [N];
    logic signed [DW-1:0] dl_q;
    logic signed [BW-1:0] bin_re_mem [N];
    logic signed [BW-1:0] bin_im_mem [N];
    logic signed [BW-1:0] bin_re_q, bin_im_q;
    logic signed [TW-1:0] rom_re [N];
    logic signed [TW-1:0] rom_im [N];
    logic signed [TW-1:0] tw_re_q, tw_im_q;

    logic                 a_valid_reg;
    logic [AW-1:0]        a_addr_reg;
    logic                 b_valid_reg;
    logic [AW-1:0]        b_addr_reg;
    logic signed [SW-1:0] b_s_re_reg, b_s_im_reg;
    logic signed [TW-1:0] b_tw_re_reg, b_tw_im_reg;

    logic signed [BW-1:0] freq_re_reg, freq_im_reg;
    logic                 freq_en_reg, sob_reg, eob_reg;

    logic                 accept;
    logic                 issue;
    logic [AW-1:0]        rd_addr;
    logic                 dl_we;
    logic [AW-1:0]        dl_waddr;
    logic signed [DW-1:0] dl_wdata;
    logic                 bin_we;
    logic [AW-1:0]        bin_waddr;
    logic signed [BW-1:0] res_re, res_im;

    // Twiddle ROM holds W^k = cos + j*sin, with +1.0 coded as 2^(TW-1)-1
    for (genvar gi = 0; gi < N; gi++) begin : g_tw
        localparam real ANG = 2.0 * PI * $itor(gi) / $itor(N);
        localparam real CR  = AMP * $cos(ANG);
        localparam real SR  = AMP * $sin(ANG);
        localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
        assign rom_re[gi] = TW'(CI);
        assign rom_im[gi] = TW'(SI);
    end

    function automatic logic signed [BW-1:0] sat(input logic signed [PW:0] v);
        if (v > SMAX)      return BW'(SMAX);
        else if (v < SMIN) return BW'(SMIN);
        else               return v[BW-1:0];
    endfunction

    assign accept  = bus.sample_en_i && ready_reg;
    assign issue   = (state_reg == SWEEP) && (cnt_reg < NBINS);
    assign rd_addr = cnt_reg[AW-1:0];

    assign dl_we    = (state_reg == CLEAR) || (state_reg == DIFF);
    assign dl_waddr = (state_reg == CLEAR) ? cnt_reg[AW-1:0] : ptr_reg;
    assign dl_wdata = (state_reg == CLEAR) ? '0 : sample_reg;

    assign bin_we    = b_valid_reg || (state_reg == CLEAR);
    assign bin_waddr = b_valid_reg ? b_addr_reg : cnt_reg[AW-1:0];

    always_ff @(posedge clk_i) begin
        if (dl_we)
            dl_mem[dl_waddr] <= dl_wdata;
        if (accept)
            dl_q <= dl_mem[ptr_reg];
    end

    always_ff @(posedge clk_i) begin
        if (bin_we) begin
            bin_re_mem[bin_waddr] <= b_valid_reg ? res_re : '0;
            bin_im_mem[bin_waddr] <= b_valid_reg ? res_im : '0;
        end
        bin_re_q <= bin_re_mem[rd_addr];
        bin_im_q <= bin_im_mem[rd_addr];
        tw_re_q  <= rom_re[rd_addr];
        tw_im_q  <= rom_im[rd_addr];
    end

    always_comb begin
        logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
        logic signed [PW:0]   sum_re, sum_im, rnd_re, rnd_im;
        p_rr   = b_s_re_reg * b_tw_re_reg;
        p_ii   = b_s_im_reg * b_tw_im_reg;
        p_ri   = b_s_re_reg * b_tw_im_reg;
        p_ir   = b_s_im_reg * b_tw_re_reg;
        sum_re = PW1'(p_rr) - PW1'(p_ii);
        sum_im = PW1'(p_ri) + PW1'(p_ir);
        rnd_re = (sum_re + HALF) >>> (TW - 1);
        rnd_im = (sum_im + HALF) >>> (TW - 1);
        res_re = sat(rnd_re);
        res_im = sat(rnd_im);
        // Bin 0 twiddle is not exactly 1.0, so the accumulator passes straight through
        if (b_addr_reg == '0) begin
            res_re = sat(PW1'(b_s_re_reg));
            res_im = sat(PW1'(b_s_im_reg));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= CLEAR;
            cnt_reg     <= '0;
            ptr_reg     <= '0;
            sample_reg  <= '0;
            diff_reg    <= '0;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= bus.sample_en_i && !ready_reg;
            case (state_reg)
                CLEAR: begin
                    if (cnt_reg == CLEAR_LAST) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + (AW + 2)'(1);
                    end
                end
                IDLE: begin
                    if (bus.sample_en_i) begin
                        sample_reg <= bus.sample_i;
                        state_reg  <= DIFF;
                        ready_reg  <= 1'b0;
                    end
                end
                DIFF: begin
                    diff_reg  <= (DW + 1)'(sample_reg) - (DW + 1)'(dl_q);
                    ptr_reg   <= ptr_reg + AW'(1);
                    cnt_reg   <= '0;
                    state_reg <= SWEEP;
                end
                SWEEP: begin
                    // Held past the last issue until the pipeline has drained bin N-1
                    if (cnt_reg == SWEEP_LAST) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + (AW + 2)'(1);
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_valid_reg <= 1'b0;
            a_addr_reg  <= '0;
            b_valid_reg <= 1'b0;
            b_addr_reg  <= '0;
            b_s_re_reg  <= '0;
            b_s_im_reg  <= '0;
            b_tw_re_reg <= '0;
            b_tw_im_reg <= '0;
            freq_re_reg <= '0;
            freq_im_reg <= '0;
            freq_en_reg <= 1'b0;
            sob_reg     <= 1'b0;
            eob_reg     <= 1'b0;
        end else begin
            a_valid_reg <= issue;
            a_addr_reg  <= rd_addr;
            b_valid_reg <= a_valid_reg;
            if (a_valid_reg) begin
                b_addr_reg  <= a_addr_reg;
                b_s_re_reg  <= SW'(bin_re_q) + SW'(diff_reg);
                b_s_im_reg  <= SW'(bin_im_q);
                b_tw_re_reg <= tw_re_q;
                b_tw_im_reg <= tw_im_q;
            end
            freq_en_reg <= b_valid_reg;
            sob_reg     <= b_valid_reg && (b_addr_reg == '0);
            eob_reg     <= b_valid_reg && (b_addr_reg == LAST_BIN);
            if (b_valid_reg) begin
                freq_re_reg <= res_re;
                freq_im_reg <= res_im;
            end
        end
    end

    assign bus.ready_o   = ready_reg;
    assign bus.overrun_o = overrun_reg;
    assign bus.sob_o     = sob_reg;
    assign bus.eob_o     = eob_reg;
    assign bus.freq_en_o = freq_en_reg;
    assign bus.freq_re_o = freq_re_reg;
    assign bus.freq_im_o = freq_im_reg;
endmodule

// File: tb/tb_sdft_bin_engine.sv
// Directed bench for sdft_bin_engine: N=16 instance for framing/impulse/DC/overrun/reset,
// plus a BW=16 instance for saturation.
module tb_sdft_bin_engine;
    localparam int DW  = 16;
    localparam int N   = 16;
    localparam int BWA = 20;
    localparam int BWB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    sdft_bin_engine_if #(.DW(DW), .BW(BWA)) ifa();
    sdft_bin_engine_if #(.DW(DW), .BW(BWB)) ifb();

    sdft_bin_engine #(.DW(DW), .N(N), .BW(BWA)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_a),
        .bus     (ifa.slave)
    );

    sdft_bin_engine #(.DW(DW), .N(N), .BW(BWB)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_b),
        .bus     (ifb.slave)
    );

    // Capture of DUT A frames
    logic signed [BWA-1:0] cap_re [N];
    logic signed [BWA-1:0] cap_im [N];
    int idx_a = 0, sob_cyc = 0, eob_cyc = 0, ovr_cnt = 0, ovr_cyc = 0, en_cnt = 0;

    always @(negedge clk) begin
        if (ifa.overrun_o) begin
            ovr_cnt <= ovr_cnt + 1;
            ovr_cyc <= cyc;
        end
        if (ifa.freq_en_o) begin
            en_cnt <= en_cnt + 1;
            if (ifa.sob_o) begin
                cap_re[0] <= ifa.freq_re_o;
                cap_im[0] <= ifa.freq_im_o;
                idx_a     <= 1;
                sob_cyc   <= cyc;
            end else begin
                if (idx_a < N) begin
                    cap_re[idx_a] <= ifa.freq_re_o;
                    cap_im[idx_a] <= ifa.freq_im_o;
                end
                idx_a <= idx_a + 1;
            end
            if (ifa.eob_o) eob_cyc <= cyc;
        end
    end

    logic signed [BWB-1:0] b0_re, b0_im;
    always @(negedge clk) begin
        if (ifb.freq_en_o && ifb.sob_o) begin
            b0_re <= ifb.freq_re_o;
            b0_im <= ifb.freq_im_o;
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp, input logic signed [63:0] tol);
        tests++;
        assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d +-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (cyc < target) chk("wait_cyc_timeout", cyc, target);
    endtask

    task automatic measure_clear(output int n, output int bad);
        n = 0;
        bad = 0;
        while (!ifa.ready_o && n < 100) begin
            if (ifa.freq_en_o || ifa.sob_o || ifa.eob_o || ifa.overrun_o) bad++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ready_a(output int t);
        int n = 0;
        while (!ifa.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifa.ready_o) chk("ready_timeout_a", ifa.ready_o, 1);
        t = cyc;
    endtask

    task automatic send_a(input logic signed [DW-1:0] v, output int acc);
        int t;
        wait_ready_a(t);
        ifa.sample_i    = v;
        ifa.sample_en_i = 1'b1;
        acc = cyc;
        @(negedge clk);
        ifa.sample_en_i = 1'b0;
    endtask

    // Waits for ready to return, then one more cycle so the monitor has settled
    task automatic finish_a(output int t);
        wait_ready_a(t);
        @(negedge clk);
    endtask

    task automatic send_b(input logic signed [DW-1:0] v);
        int n = 0;
        while (!ifb.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifb.ready_o) chk("ready_timeout_b", ifb.ready_o, 1);
        ifb.sample_i    = v;
        ifb.sample_en_i = 1'b1;
        @(negedge clk);
        ifb.sample_en_i = 1'b0;
        n = 0;
        while (!ifb.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifb.ready_o) chk("frame_timeout_b", ifb.ready_o, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, r, n, bad, e0, o0;
        ifa.sample_i = '0; ifa.sample_en_i = 1'b0;
        ifb.sample_i = '0; ifb.sample_en_i = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {ifa.ready_o, ifa.overrun_o, ifa.sob_o, ifa.eob_o, ifa.freq_en_o,
                           ifa.freq_re_o, ifa.freq_im_o}, 0);
        chk("rst_outs_b", {ifb.ready_o, ifb.overrun_o, ifb.sob_o, ifb.eob_o, ifb.freq_en_o,
                           ifb.freq_re_o, ifb.freq_im_o}, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        measure_clear(n, bad);
        chk("clear_len", n, 16);
        chk("clear_quiet", bad, 0);

        // Impulse of 1000
        send_a(16'sd1000, acc);
        finish_a(r);
        chk("imp_b0_re", cap_re[0], 1000);
        chk("imp_b0_im", cap_im[0], 0);
        chk_tol("imp_b4_re", cap_re[4], 0, 1);
        chk_tol("imp_b4_im", cap_im[4], 1000, 1);
        chk_tol("imp_b8_re", cap_re[8], -1000, 1);
        chk_tol("imp_b8_im", cap_im[8], 0, 1);
        chk("imp_sob_cycle", sob_cyc - acc, 5);
        chk("imp_eob_cycle", eob_cyc - acc, 20);
        chk("imp_nbins", idx_a, 16);
        chk("imp_ready_cycle", r - acc, 21);

        // Reset in the middle of a sweep
        send_a(16'sd300, acc);
        wait_cyc(acc + 10);
        rst_a = 1'b0;
        @(negedge clk);
        e0 = en_cnt;
        repeat (3) @(negedge clk);
        chk("rstmid_outs", {ifa.ready_o, ifa.freq_en_o, ifa.sob_o, ifa.eob_o, ifa.freq_re_o}, 0);
        rst_a = 1'b1;
        measure_clear(n, bad);
        chk("rstmid_no_en", en_cnt - e0, 0);
        chk("rstmid_clear_len", n, 16);
        chk("rstmid_clear_quiet", bad, 0);
        send_a(16'sd1000, acc);
        finish_a(r);
        chk("rstmid_imp_b0_re", cap_re[0], 1000);
        chk("rstmid_imp_b0_im", cap_im[0], 0);

        // DC: 16 samples of 100, then one more
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        measure_clear(n, bad);
        chk("dc_clear_len", n, 16);
        for (int i = 0; i < 17; i++) begin
            send_a(16'sd100, acc);
            finish_a(r);
            if (i == 15) chk("dc16_b0_re", cap_re[0], 1600);
        end
        chk("dc_b0_re", cap_re[0], 1600);
        chk("dc_b0_im", cap_im[0], 0);
        for (int k = 1; k < N; k++) begin
            chk_tol($sformatf("dc_b%0d_re", k), cap_re[k], 0, 16);
            chk_tol($sformatf("dc_b%0d_im", k), cap_im[k], 0, 16);
        end

        // Overrun at cycle 3 of a sweep; x[n-N]=100 so bin0 becomes 1600+400
        o0 = ovr_cnt;
        send_a(16'sd500, acc);
        wait_cyc(acc + 3);
        ifa.sample_i    = 16'sd7777;
        ifa.sample_en_i = 1'b1;
        @(negedge clk);
        ifa.sample_en_i = 1'b0;
        finish_a(r);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_cycle", ovr_cyc - acc, 4);
        chk("ovr_b0_re", cap_re[0], 2000);
        chk("ovr_nbins", idx_a, 16);
        chk("ovr_ready_cycle", r - acc, 21);

        // sample_en coincident with eob is dropped
        o0 = ovr_cnt;
        send_a(16'sd100, acc);
        wait_cyc(acc + 20);
        chk("eobcol_eob", ifa.eob_o, 1);
        chk("eobcol_ready", ifa.ready_o, 0);
        ifa.sample_i    = 16'sd5000;
        ifa.sample_en_i = 1'b1;
        @(negedge clk);
        ifa.sample_en_i = 1'b0;
        finish_a(r);
        chk("eobcol_pulses", ovr_cnt - o0, 1);
        chk("eobcol_ovr_cycle", ovr_cyc - acc, 21);
        chk("eobcol_b0_re", cap_re[0], 2000);

        // Follow-up frame: dropped samples must not have entered the delay line
        o0 = ovr_cnt;
        send_a(16'sd100, acc);
        finish_a(r);
        chk("after_b0_re", cap_re[0], 2000);
        chk("after_b0_im", cap_im[0], 0);
        chk("after_no_ovr", ovr_cnt - o0, 0);

        // Saturation with BW=16: full-scale DC must clamp at 32767
        for (int i = 0; i < 4; i++) begin
            send_b(16'sd32767);
            chk($sformatf("sat_b0_re_%0d", i), b0_re, 32767);
            chk($sformatf("sat_b0_im_%0d", i), b0_im, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
